// File: rtl/input_debouncer_pkg.sv
// Shared types for the input debouncer: FSM state encoding and a state decode helper.
package input_debouncer_pkg;

  typedef enum logic [1:0] {
    ST_LO     = 2'd0,
    ST_CHK_HI = 2'd1,
    ST_HI     = 2'd2,
    ST_CHK_LO = 2'd3
  } state_t;

  function automatic logic is_chk(input state_t s);
    return (s == ST_CHK_HI) || (s == ST_CHK_LO);
  endfunction

endpackage

// File: rtl/input_debouncer_bit_synchronizer.sv
// Multi-flop synchronizer for one asynchronous bit; all stages reset to 0.
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_ff;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[STAGES-2:0], d};
    end
  end

  assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Synchronizes and debounces a raw input into a clean level with registered rise/fall pulses.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 16,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_raw,
  input  logic       i_enable,
  output logic       o_level,
  output logic       o_rise,
  output logic       o_fall,
  output logic       o_busy,
  output logic [1:0] dbg_state
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             s_sync;
  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             level_next;
  logic             rise_next;
  logic             fall_next;
  logic             busy_next;

  bit_synchronizer #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rstn(rstn),
    .d   (i_raw),
    .q   (s_sync)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_LO;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
    end
  end

  // Dropping enable while qualifying takes priority over a commit in the same cycle.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    unique case (state)
      ST_LO: begin
        if (s_sync && i_enable) begin
          next_state = ST_CHK_HI;
          cnt_next   = '0;
        end
      end
      ST_CHK_HI: begin
        if (!i_enable || !s_sync) begin
          next_state = ST_LO;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          next_state = ST_HI;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      ST_HI: begin
        if (!s_sync && i_enable) begin
          next_state = ST_CHK_LO;
          cnt_next   = '0;
        end
      end
      ST_CHK_LO: begin
        if (!i_enable || s_sync) begin
          next_state = ST_HI;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          next_state = ST_LO;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        next_state = ST_LO;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    level_next = (next_state == ST_HI) || (next_state == ST_CHK_LO);
    rise_next  = (state == ST_CHK_HI) && (next_state == ST_HI);
    fall_next  = (state == ST_CHK_LO) && (next_state == ST_LO);
    busy_next  = is_chk(next_state);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_level <= 1'b0;
      o_rise  <= 1'b0;
      o_fall  <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      o_level <= level_next;
      o_rise  <= rise_next;
      o_fall  <= fall_next;
      o_busy  <= busy_next;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with SYNC_STAGES=2, DEB_CYCLES=4.
module tb_input_debouncer;

  localparam int SS  = 2;
  localparam int DEB = 4;
  localparam int W   = 6;

  // Observed vector: {o_level, o_rise, o_fall, o_busy, dbg_state}
  localparam logic [W-1:0] V_LO   = 6'b0000_00;
  localparam logic [W-1:0] V_CHKH = 6'b0001_01;
  localparam logic [W-1:0] V_HIC  = 6'b1100_10;
  localparam logic [W-1:0] V_HI   = 6'b1000_10;
  localparam logic [W-1:0] V_CHKL = 6'b1001_11;
  localparam logic [W-1:0] V_LOC  = 6'b0010_00;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       i_raw = 1'b0;
  logic       i_enable = 1'b1;
  logic       o_level, o_rise, o_fall, o_busy;
  logic [1:0] dbg_state;

  logic [W-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  input_debouncer #(
    .SYNC_STAGES(SS),
    .DEB_CYCLES (DEB),
    .CNT_W      (8)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .i_raw    (i_raw),
    .i_enable (i_enable),
    .o_level  (o_level),
    .o_rise   (o_rise),
    .o_fall   (o_fall),
    .o_busy   (o_busy),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic push_n(input logic [W-1:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  task automatic check(input string tag);
    logic [W-1:0] obs;
    logic [W-1:0] exp_v;
    obs = {o_level, o_rise, o_fall, o_busy, dbg_state};
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s: observed=%b but expected queue is empty", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) else begin
        fails++;
        $error("FAIL %s: observed=%b expected=%b", tag, obs, exp_v);
      end
    end
  endtask

  task automatic tick(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check(tag);
    end
  endtask

  initial begin
    // Reset held with raw high: everything stays zero
    rstn = 1'b0;
    i_raw = 1'b1;
    #1;
    push_n(V_LO, 1);
    check("reset_async");
    push_n(V_LO, 2);
    tick("reset_hold", 2);

    // Release reset with raw high: commits after edge SS+DEB
    rstn = 1'b1;
    push_n(V_LO, SS);
    push_n(V_CHKH, DEB);
    push_n(V_HIC, 1);
    push_n(V_HI, 2);
    tick("reset_release_rise", SS + DEB + 3);

    // Clean fall
    i_raw = 1'b0;
    push_n(V_HI, SS);
    push_n(V_CHKL, DEB);
    push_n(V_LOC, 1);
    push_n(V_LO, 2);
    tick("clean_fall", SS + DEB + 3);

    // Glitch: 3 cycles high is shorter than qualification
    i_raw = 1'b1;
    push_n(V_LO, 2);
    push_n(V_CHKH, 3);
    push_n(V_LO, 3);
    tick("glitch_a", 3);
    i_raw = 1'b0;
    tick("glitch_b", 5);

    // Clean rise
    i_raw = 1'b1;
    push_n(V_LO, SS);
    push_n(V_CHKH, DEB);
    push_n(V_HIC, 1);
    push_n(V_HI, 2);
    tick("clean_rise", SS + DEB + 3);

    // Enable drops in the same cycle the fall would commit: abort wins
    i_raw = 1'b0;
    push_n(V_HI, SS);
    push_n(V_CHKL, DEB);
    push_n(V_HI, 2);
    tick("en_vs_commit_a", SS + DEB);
    i_enable = 1'b0;
    tick("en_vs_commit_b", 2);
    i_enable = 1'b1;
    push_n(V_CHKL, DEB);
    push_n(V_LOC, 1);
    push_n(V_LO, 1);
    tick("en_vs_commit_c", DEB + 2);

    // Reset in the middle of a rise qualification
    i_raw = 1'b1;
    push_n(V_LO, 2);
    push_n(V_CHKH, 1);
    tick("rst_mid_a", 3);
    rstn = 1'b0;
    #1;
    push_n(V_LO, 1);
    check("rst_mid_async");
    push_n(V_LO, 2);
    tick("rst_mid_hold", 2);
    i_raw = 1'b0;
    rstn = 1'b1;
    push_n(V_LO, 3);
    tick("rst_mid_release", 3);

    // Enable abort two cycles into CHK_HI, then re-enable and commit
    i_raw = 1'b1;
    push_n(V_LO, 2);
    push_n(V_CHKH, 2);
    push_n(V_LO, 2);
    push_n(V_CHKH, DEB);
    push_n(V_HIC, 1);
    push_n(V_HI, 1);
    tick("en_abort_a", 4);
    i_enable = 1'b0;
    tick("en_abort_b", 2);
    i_enable = 1'b1;
    tick("en_abort_c", DEB + 2);

    // Random short glitches from HI never disturb the level
    for (int k = 0; k < 6; k++) begin
      int len;
      len = $urandom_range(1, DEB - 1);
      i_raw = 1'b0;
      push_n(V_HI, 2);
      push_n(V_CHKL, len);
      push_n(V_HI, 2);
      tick("rand_glitch_a", len);
      i_raw = 1'b1;
      tick("rand_glitch_b", 4);
    end

    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain: observed=%0d leftover entries expected=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
